// File: rtl/cpu_fetch_stage_pkg.sv
// Shared constants for the IF stage: redirect encodings, hazard vector indices, NOP.
// Latency: none (constants and one pure helper function).
// Backpressure: none; stall/flush indices are used by the fetch-stage consumers.
package cpu_fetch_stage_pkg;

   // EX-stage PC redirect codes; 2'b11 is reserved and treated as no redirect.
   localparam logic [1:0] PC_INC_NORMAL = 2'b00;
   localparam logic [1:0] PC_INC_BRANCH = 2'b01;
   localparam logic [1:0] PC_INC_JUMP   = 2'b10;

   // Stall/flush vectors are packed {IF,ID,EX,MEM,WB}, so IF is the MSB.
   localparam int HAZARD_STALL_IF  = 4;
   localparam int HAZARD_STALL_ID  = 3;
   localparam int HAZARD_STALL_EX  = 2;
   localparam int HAZARD_STALL_MEM = 1;
   localparam int HAZARD_STALL_WB  = 0;
   localparam int HAZARD_FLUSH_IF  = 4;
   localparam int HAZARD_FLUSH_ID  = 3;
   localparam int HAZARD_FLUSH_EX  = 2;
   localparam int HAZARD_FLUSH_MEM = 1;
   localparam int HAZARD_FLUSH_WB  = 0;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   function automatic logic is_redirect(input logic [1:0] code);
      return (code == PC_INC_BRANCH) || (code == PC_INC_JUMP);
   endfunction

endpackage

// File: rtl/cpu_pc_next_mux.sv
// Next-PC select: redirect target, hold, or sequential PC+4; also flags redirect/misalign.
// Latency: purely combinational.
// Backpressure: hold input freezes the PC; a redirect overrides hold.
// Ports: pc (current PC), hold (IF stall or flush), pc_inc (EX redirect code),
//        branch_target / jump_target (byte targets), pc_next, redir, misalign.
module cpu_pc_next_mux
   import cpu_fetch_stage_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        hold,
   input  logic [1:0]  pc_inc,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   output logic [31:0] pc_next,
   output logic        redir,
   output logic        misalign
);

   logic [31:0] target;

   always_comb begin
      redir    = is_redirect(pc_inc);
      target   = (pc_inc == PC_INC_JUMP) ? jump_target : branch_target;
      misalign = redir && (target[1:0] != 2'b00);
      if (redir) begin
         // Low bits are dropped so fetch stays word aligned; misalign records the fault.
         pc_next = {target[31:2], 2'b00};
      end else if (hold) begin
         pc_next = pc;
      end else begin
         pc_next = pc + 32'd4;
      end
   end

endmodule

// File: rtl/cpu_fetch_stage.sv
// IF stage + IF/ID latch: owns the PC, addresses instruction memory, latches fetched word.
// Latency: 1 cycle from PC to ID latch; redirect at edge N fetches the target after N.
// Backpressure: stalls[IF] holds the PC, stalls[ID] holds the latch; flush/redirect inject bubbles.
// Ports: clk, clr (sync high reset), stalls/flushs (hazard vectors), pc_inc_realtime_ex,
//        branch/jump targets, im_addr/im_data (IMEM), pc_if, ID latch outputs,
//        misalign_err (sticky), fetch/stall/flush debug counters.
module cpu_fetch_stage
   import cpu_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          IM_ADDR_WIDTH = 10
) (
   input  logic                     clk,
   input  logic                     clr,
   input  logic [4:0]               stalls,
   input  logic [4:0]               flushs,
   input  logic [1:0]               pc_inc_realtime_ex,
   input  logic [31:0]              branch_target_ex,
   input  logic [31:0]              jump_target_ex,
   output logic [IM_ADDR_WIDTH-1:0] im_addr,
   input  logic [31:0]              im_data,
   output logic [31:0]              pc_if,
   output logic [31:0]              instr_id,
   output logic [31:0]              pc_id,
   output logic [31:0]              pc_plus4_id,
   output logic                     valid_id,
   output logic                     misalign_err,
   output logic [31:0]              fetch_count,
   output logic [31:0]              stall_count,
   output logic [31:0]              flush_count
);

   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic        redir;
   logic        misalign;
   logic        stall_if;
   logic        stall_id;
   logic        flush_if;
   logic        flush_id;

   assign stall_if = stalls[HAZARD_STALL_IF];
   assign stall_id = stalls[HAZARD_STALL_ID];
   assign flush_if = flushs[HAZARD_FLUSH_IF];
   assign flush_id = flushs[HAZARD_FLUSH_ID];

   // Only the IF and ID bits of the hazard vectors matter to this stage.
   logic unused_hazard_bits;
   assign unused_hazard_bits = &{1'b0, stalls[2:0], flushs[2:0]};

   assign pc_plus4 = pc_if + 32'd4;
   assign im_addr  = pc_if[IM_ADDR_WIDTH+1:2];

   cpu_pc_next_mux u_pc_next_mux (
      .pc            (pc_if),
      .hold          (stall_if | flush_if),
      .pc_inc        (pc_inc_realtime_ex),
      .branch_target (branch_target_ex),
      .jump_target   (jump_target_ex),
      .pc_next       (pc_next),
      .redir         (redir),
      .misalign      (misalign)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         pc_if        <= RESET_PC;
         instr_id     <= INSTR_NOP;
         pc_id        <= RESET_PC;
         pc_plus4_id  <= RESET_PC + 32'd4;
         valid_id     <= 1'b0;
         misalign_err <= 1'b0;
         fetch_count  <= 32'd0;
         stall_count  <= 32'd0;
         flush_count  <= 32'd0;
      end else begin
         pc_if <= pc_next;
         if (misalign) begin
            misalign_err <= 1'b1;
         end
         // A redirect moves the PC even under stall, so that cycle is not a held cycle.
         if (stall_if && !redir) begin
            stall_count <= stall_count + 32'd1;
         end
         // Redirect squashes the instruction fetched this cycle: it is wrong-path.
         if (flush_id || redir) begin
            instr_id    <= INSTR_NOP;
            valid_id    <= 1'b0;
            pc_id       <= pc_if;
            pc_plus4_id <= pc_plus4;
            flush_count <= flush_count + 32'd1;
         end else if (!stall_id) begin
            instr_id    <= im_data;
            valid_id    <= 1'b1;
            pc_id       <= pc_if;
            pc_plus4_id <= pc_plus4;
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_fetch_stage.sv
module tb_cpu_fetch_stage;
   import cpu_fetch_stage_pkg::*;

   localparam logic [4:0] S_NONE = 5'b00000;
   localparam logic [4:0] S_IF   = 5'b10000;
   localparam logic [4:0] S_ID   = 5'b01000;
   localparam logic [4:0] S_BOTH = 5'b11000;

   logic        clk;
   logic        clr;
   logic [4:0]  stalls;
   logic [4:0]  flushs;
   logic [1:0]  pc_inc_realtime_ex;
   logic [31:0] branch_target_ex;
   logic [31:0] jump_target_ex;
   logic [9:0]  im_addr;
   logic [31:0] im_data;
   logic [31:0] pc_if;
   logic [31:0] instr_id;
   logic [31:0] pc_id;
   logic [31:0] pc_plus4_id;
   logic        valid_id;
   logic        misalign_err;
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
   logic [31:0] flush_count;

   cpu_fetch_stage #(.RESET_PC(32'h0000_0000), .IM_ADDR_WIDTH(10)) dut (
      .clk                (clk),
      .clr                (clr),
      .stalls             (stalls),
      .flushs             (flushs),
      .pc_inc_realtime_ex (pc_inc_realtime_ex),
      .branch_target_ex   (branch_target_ex),
      .jump_target_ex     (jump_target_ex),
      .im_addr            (im_addr),
      .im_data            (im_data),
      .pc_if              (pc_if),
      .instr_id           (instr_id),
      .pc_id              (pc_id),
      .pc_plus4_id        (pc_plus4_id),
      .valid_id           (valid_id),
      .misalign_err       (misalign_err),
      .fetch_count        (fetch_count),
      .stall_count        (stall_count),
      .flush_count        (flush_count)
   );

   // Instruction memory model: each word encodes its own word address.
   assign im_data = {6'h2A, 16'hBEEF, im_addr};

   function automatic logic [31:0] ins(input logic [31:0] a);
      return {6'h2A, 16'hBEEF, a[11:2]};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] pc;
      logic        vld;
      logic [31:0] instr;
      logic [31:0] pcid;
      logic [31:0] fc;
      logic [31:0] sc;
      logic [31:0] flc;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: after every rising edge, compare the DUT state with the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc_if", pc_if, e.pc);
            chk("im_addr", {22'd0, im_addr}, {22'd0, e.pc[11:2]});
            chk("valid_id", {31'd0, valid_id}, {31'd0, e.vld});
            chk("instr_id", instr_id, e.instr);
            chk("pc_id", pc_id, e.pcid);
            chk("pc_plus4_id", pc_plus4_id, e.pcid + 32'd4);
            chk("fetch_count", fetch_count, e.fc);
            chk("stall_count", stall_count, e.sc);
            chk("flush_count", flush_count, e.flc);
            chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
         end
      end
   end

   // Drive one cycle of inputs on the falling edge and queue the state expected after the next rise.
   task automatic step(input logic c, input logic [4:0] st, input logic [4:0] fl,
                       input logic [1:0] inc, input logic [31:0] bt, input logic [31:0] jt,
                       input logic [31:0] e_pc, input logic e_vld, input logic [31:0] e_instr,
                       input logic [31:0] e_pcid, input logic [31:0] e_fc, input logic [31:0] e_sc,
                       input logic [31:0] e_flc, input logic e_mis);
      exp_t e;
      @(negedge clk);
      clr                = c;
      stalls             = st;
      flushs             = fl;
      pc_inc_realtime_ex = inc;
      branch_target_ex   = bt;
      jump_target_ex     = jt;
      e.pc = e_pc; e.vld = e_vld; e.instr = e_instr; e.pcid = e_pcid;
      e.fc = e_fc; e.sc = e_sc; e.flc = e_flc; e.mis = e_mis;
      exp_q.push_back(e);
   endtask

   initial begin
      clr = 1'b1; stalls = '0; flushs = '0;
      pc_inc_realtime_ex = PC_INC_NORMAL; branch_target_ex = '0; jump_target_ex = '0;
      //   clr  stalls  flushs  pc_inc         btgt          jtgt           pc_if         vld  instr                 pc_id         fc  sc  flc mis
      step(1, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h0,        0, 32'h0,                32'h0,        0,  0,  0,  0);
      step(0, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h4,        1, ins(32'h0),           32'h0,        1,  0,  0,  0);
      step(0, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h8,        1, ins(32'h4),           32'h4,        2,  0,  0,  0);
      // load-use stall at pc 8
      step(0, S_BOTH, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h8,        1, ins(32'h4),           32'h4,        2,  1,  0,  0);
      step(0, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'hC,        1, ins(32'h8),           32'h8,        3,  1,  0,  0);
      step(0, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h10,       1, ins(32'hC),           32'hC,        4,  1,  0,  0);
      // branch at pc 0x10
      step(0, S_NONE, S_NONE, PC_INC_BRANCH, 32'h100,     32'h0,         32'h100,      0, 32'h0,                32'h10,       4,  1,  1,  0);
      step(0, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h104,      1, ins(32'h100),         32'h100,      5,  1,  1,  0);
      // jump beats stall
      step(0, S_BOTH, S_NONE, PC_INC_JUMP,   32'h0,       32'h200,       32'h200,      0, 32'h0,                32'h104,      5,  1,  2,  0);
      step(0, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h204,      1, ins(32'h200),         32'h200,      6,  1,  2,  0);
      // misaligned jump
      step(0, S_NONE, S_NONE, PC_INC_JUMP,   32'h0,       32'h203,       32'h200,      0, 32'h0,                32'h204,      6,  1,  3,  1);
      step(0, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h204,      1, ins(32'h200),         32'h200,      7,  1,  3,  1);
      // flush IF+ID: PC holds, bubble, not a stall
      step(0, S_NONE, S_BOTH, PC_INC_NORMAL, 32'h0,       32'h0,         32'h204,      0, 32'h0,                32'h204,      7,  1,  4,  1);
      // stall ID with flush ID: flush wins
      step(0, S_ID,   S_ID,   PC_INC_NORMAL, 32'h0,       32'h0,         32'h208,      0, 32'h0,                32'h204,      7,  1,  5,  1);
      // reserved code 2'b11 is not a redirect
      step(0, S_NONE, S_NONE, 2'b11,         32'h300,     32'h400,       32'h20C,      1, ins(32'h208),         32'h208,      8,  1,  5,  1);
      // IF stall only: PC holds, ID reloads
      step(0, S_IF,   S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h20C,      1, ins(32'h20C),         32'h20C,      9,  2,  5,  1);
      // reset during stall and jump
      step(1, S_BOTH, S_BOTH, PC_INC_JUMP,   32'h0,       32'h500,       32'h0,        0, 32'h0,                32'h0,        0,  0,  0,  0);
      step(0, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h4,        1, ins(32'h0),           32'h0,        1,  0,  0,  0);
      // PC wrap
      step(0, S_NONE, S_NONE, PC_INC_JUMP,   32'h0,       32'hFFFFFFFC,  32'hFFFFFFFC, 0, 32'h0,                32'h4,        1,  0,  1,  0);
      step(0, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h0,        1, ins(32'hFFFFFFFC),    32'hFFFFFFFC, 2,  0,  1,  0);
      step(0, S_NONE, S_NONE, PC_INC_NORMAL, 32'h0,       32'h0,         32'h4,        1, ins(32'h0),           32'h0,        3,  0,  1,  0);
      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cpu_fetch_stage.md
Name: cpu_fetch_stage

Overview:
- IF stage and IF/ID pipeline latch of the 5-stage MIPS core.
- Owns the PC and drives the instruction-memory address. Captures the fetched word into the ID latch.
- Consumes the stall/flush vectors and EX-stage PC redirect produced by cpu_hazard_unit. This block is the receiving end of that stall/flush protocol.

Parameters:
- RESET_PC, 32'h00000000, byte address loaded into PC on clr.
- IM_ADDR_WIDTH, 10, word-address width of instruction memory.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- clr  in  1  reset, synchronous, active-high.
- stalls  in  5  per-stage stall {IF,ID,EX,MEM,WB}, indexed by `HAZARD_STALL_*; only IF and ID bits are used.
- flushs  in  5  per-stage flush, indexed by `HAZARD_FLUSH_*; only IF and ID bits are used.
- pc_inc_realtime_ex  in  2  EX redirect code: `PC_INC_NORMAL, `PC_INC_BRANCH or `PC_INC_JUMP.
- branch_target_ex  in  32  branch target byte address.
- jump_target_ex  in  32  jump target byte address.
- im_addr  out  IM_ADDR_WIDTH  equals pc_if[IM_ADDR_WIDTH+1:2], combinational.
- im_data  in  32  instruction word; combinational read of im_addr.
- pc_if  out  32  current PC.
- instr_id  out  32  instruction held in the ID latch.
- pc_id  out  32  PC of instr_id.
- pc_plus4_id  out  32  pc_id+4, registered.
- valid_id  out  1  ID latch holds a real instruction (0 = bubble).
- misalign_err  out  1  sticky: a redirect target had bits[1:0] != 0.
- fetch_count  out  32  debug: count of valid instructions loaded into ID.
- stall_count  out  32  debug: count of cycles in which the IF stall held the PC.
- flush_count  out  32  debug: count of bubbles inserted by flush.

Behaviour:
- Reset (clr=1 at posedge): pc_if=RESET_PC; instr_id=0 (NOP); pc_id=RESET_PC; pc_plus4_id=RESET_PC+4; valid_id=0; misalign_err=0; all counters=0. clr overrides every other input.
- Redirect: redir = pc_inc_realtime_ex is `PC_INC_BRANCH or `PC_INC_JUMP. Code 2'b11 and `PC_INC_NORMAL are both non-redirect.
- Next-PC priority:
  1. redir: target is branch_target_ex or jump_target_ex, with bits[1:0] forced to 0.
  2. else stalls[IF]=1 or flushs[IF]=1: PC holds.
  3. else pc_if+4, wrapping modulo 2^32.
- Redirect beats stall. The stalled ID instruction is wrong-path in that case.
- ID latch priority:
  1. flushs[ID]=1 or redir: load bubble (instr_id=0, valid_id=0). pc_id and pc_plus4_id take pc_if and pc_if+4.
  2. else stalls[ID]=1: hold every ID field.
  3. else load instr_id=im_data, pc_id=pc_if, pc_plus4_id=pc_if+4, valid_id=1.
- Simultaneous stall[ID] and flush[ID]: flush wins (bubble).
- Latency: 1 cycle from PC to ID latch. A redirect seen at posedge N puts the target in pc_if after N; its instruction reaches ID at N+1.
- misalign_err sets when redir and the selected target has bits[1:0] != 0. Cleared only by clr.
- Counters, each +1 per posedge, 32-bit wrap, no saturation:
  - fetch_count: ID latch loads a valid instruction.
  - stall_count: stalls[IF]=1 and !redir.
  - flush_count: a bubble is loaded because of flushs[ID] or redir.
- Stall/flush inputs are produced on negedge by the hazard unit and are sampled only at posedge; no combinational path from them to outputs.
- Reset mid-stall or mid-redirect: clr wins; the next cycle fetches RESET_PC.

Decomposition:
- Shared constants stay in defines.vh: `PC_INC_* encodings, `HAZARD_STALL_*/`HAZARD_FLUSH_* indices, and a new `INSTR_NOP 32'h00000000.
- One combinational sub-module, cpu_pc_next_mux: computes next PC, the redir flag and the misalign flag.
- The top holds the PC register, ID latch and counters.

Test Plan:
- Free run: clr 1 cycle, im_data=pc-derived pattern, 4 cycles -> pc_if 0,4,8,C; instr_id follows one cycle later; fetch_count=3, valid_id=1 from cycle 2.
- Load-use stall: stalls[IF]=stalls[ID]=1 for 1 cycle at pc_if=8 -> pc_if stays 8, ID holds the instruction from pc 4; stall_count=1; then resumes to C.
- Branch: pc_inc=`PC_INC_BRANCH, branch_target_ex=0x100 at pc_if=0x10 -> next pc_if=0x100, valid_id=0 for 1 cycle, flush_count=1; next ID gets instr@0x100.
- Redirect vs stall: `PC_INC_JUMP to 0x200 with stalls[IF,ID]=1 in the same cycle -> pc_if=0x200, bubble in ID, stall_count unchanged.
- Misaligned jump: jump_target_ex=0x203 -> pc_if=0x200, misalign_err=1, stays 1 until clr.
- Reset mid-stall: clr=1 with stalls active at pc_if=0x40 -> pc_if=RESET_PC, valid_id=0, all counters 0; wrap check: pc_if=0xFFFFFFFC free-runs to 0x00000000.
